fn_sweep_ctrl: RTL

- Sequencer that drives the 5-input mux-based Boolean evaluator (inputs y1, y0, x2, x1, x0; output z) through all 32 input combinations.
- Captures z for each combination into a 32-bit truth table and compares it against a caller-supplied expected table.
- Reports the mismatch count and a pass flag.
- Sits beside the evaluator as its stimulus/check controller for on-chip self-test.

---
 rtl/fn_sweep_ctrl_pkg.sv | 8 +
 rtl/fn_sweep_ctrl_if.sv | 26 ++
 rtl/fn_sweep_timer.sv | 20 ++
 rtl/fn_sweep_ctrl.sv | 80 ++++++++
 4 files changed

// File: rtl/fn_sweep_ctrl_pkg.sv
// fn_sweep_pkg: shared sizes and FSM state type for the Boolean evaluator sweep controller
package fn_sweep_pkg;
    localparam int N_VEC  = 32;
    localparam int IDX_W  = 5;
    localparam int CNT_W  = 6;
    localparam int WAIT_W = 4;
    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, FINISH} state_t;
endpackage

// File: rtl/fn_sweep_ctrl_if.sv
// fn_sweep_ctrl_if: control, result and evaluator signals between the sweep controller and its user
interface fn_sweep_ctrl_if;
    import fn_sweep_pkg::*;
    logic             start;
    logic             abort;
    logic [N_VEC-1:0] expected;
    logic             eval_y1;
    logic             eval_y0;
    logic             eval_x2;
    logic             eval_x1;
    logic             eval_x0;
    logic             eval_z;
    logic             busy;
    logic             done;
    logic [N_VEC-1:0] table_out;
    logic [CNT_W-1:0] mismatch_cnt;
    logic             pass;
    modport master (
        output start, abort, expected, eval_z,
        input  eval_y1, eval_y0, eval_x2, eval_x1, eval_x0, busy, done, table_out, mismatch_cnt, pass
    );
    modport slave (
        input  start, abort, expected, eval_z,
        output eval_y1, eval_y0, eval_x2, eval_x1, eval_x0, busy, done, table_out, mismatch_cnt, pass
    );
endinterface

// File: rtl/fn_sweep_timer.sv
// fn_sweep_timer: settle counter with clear, flags terminal count at SETTLE_CYCLES-1
module fn_sweep_timer
    import fn_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [WAIT_W-1:0] r_wait;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_wait <= '0;
        else if (i_clr) r_wait <= '0;
        else if (i_en) r_wait <= r_wait + 1'b1;
    end
    assign o_tc = r_wait == WAIT_W'(SETTLE_CYCLES - 1);
endmodule

// File: rtl/fn_sweep_ctrl.sv
// fn_sweep_ctrl: walks the evaluator through all 32 vectors, captures z and scores it against a golden table
module fn_sweep_ctrl
    import fn_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input logic            clk,
    input logic            rst_n,
    fn_sweep_ctrl_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_VEC - 1);
    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [N_VEC-1:0] r_exp;
    logic [N_VEC-1:0] r_table;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pass;
    logic             w_tc;
    logic             w_busy;
    logic             w_done;
    logic             w_go;
    logic             w_cap;
    logic             w_en;
    logic             w_clr;
    fn_sweep_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_en  (w_en),
        .o_tc  (w_tc)
    );
    always_comb begin
        w_next = r_state;
        w_busy = r_state == SETTLE || r_state == CAPTURE;
        w_done = r_state == FINISH;
        w_go   = r_state == IDLE && bus.start && !bus.abort;
        w_cap  = r_state == CAPTURE && !bus.abort;
        w_en   = r_state == SETTLE;
        w_clr  = r_state != SETTLE;
        unique case (r_state)
            IDLE:    w_next = w_go ? SETTLE : IDLE;
            SETTLE:  w_next = bus.abort ? IDLE : (w_tc ? CAPTURE : SETTLE);
            CAPTURE: w_next = bus.abort ? IDLE : (r_idx == LAST ? FINISH : SETTLE);
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_exp   <= '0;
            r_table <= '0;
            r_cnt   <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_go) begin
                r_idx   <= '0;
                r_exp   <= bus.expected;
                r_table <= '0;
                r_cnt   <= '0;
                r_pass  <= 1'b0;
            end
            // an abort landing on a capture cycle drops that vector
            if (w_cap) begin
                r_table[r_idx] <= bus.eval_z;
                if (bus.eval_z != r_exp[r_idx]) r_cnt <= r_cnt + 1'b1;
                if (r_idx != LAST) r_idx <= r_idx + 1'b1;
            end
            if (w_done) r_pass <= r_cnt == '0;
        end
    end
    assign bus.busy         = w_busy;
    assign bus.done         = w_done;
    assign {bus.eval_y1, bus.eval_y0, bus.eval_x2, bus.eval_x1, bus.eval_x0} = w_busy ? r_idx : '0;
    assign bus.table_out    = r_table;
    assign bus.mismatch_cnt = r_cnt;
    assign bus.pass         = r_pass;
endmodule
